pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 Parameter CNT_W, default 32, perf counter width (>=2).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents in_data.
REQ-006 in_ready  output  1  stage accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  out_data valid to downstream.
REQ-009 out_ready  input  1  downstream consumes this cycle.
REQ-010 out_data  output  WIDTH  payload to downstream.
REQ-011 flush  input  1  discard all held entries (branch/jump kill).
REQ-012 bubble  input  1  refuse upstream this cycle (load-use stall); downstream side unaffected.
REQ-013 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-014 flush_cnt  output  CNT_W  flush cycles that discarded at least one valid entry.

Function
REQ-015 Storage: main entry (main_v, main_d) drives out_*; skid entry (skid_v, skid_d) holds one overflow item.
REQ-016 States: EMPTY (main_v=0), FULL (main_v=1, skid_v=0), SKID (main_v=1, skid_v=1); skid_v=1 with main_v=0 is illegal.
REQ-017 in_ready = !skid_v && !bubble; in_ready depends on no input other than bubble.
REQ-018 out_valid = main_v; out_data = main_d when main_v=1, else all zeros.
REQ-019 Accept: in_valid && in_ready; consume: out_valid && out_ready.
REQ-020 EMPTY: accept -> FULL, main_d <= in_data.
REQ-021 FULL: accept without consume -> SKID, skid_d <= in_data; accept with consume -> FULL, main_d <= in_data; consume only -> EMPTY.
REQ-022 SKID: consume -> FULL, main_d <= skid_d; no consume -> hold.
REQ-023 Latency: accepted item visible on out_* in the next cycle when the stage was EMPTY; order strictly FIFO; no item dropped or duplicated except by flush.
REQ-024 Full throughput: with out_ready=1 and bubble=0 continuously, one item per cycle.
REQ-025 flush has priority over accept, consume and bubble: next state EMPTY, both data regs zeroed, item presented in flush cycle discarded.
REQ-026 bubble with flush=0: no accept; consume and REQ-021/022 transitions apply normally.
REQ-027 Held data is stable while out_valid=1 and out_ready=0.

Reset
REQ-028 reset has priority over flush and all other inputs.
REQ-029 On reset: main_v, skid_v, main_d, skid_d, stall_cnt, flush_cnt zero; out_valid=0, out_data=0, in_ready=!bubble in the following cycle.
REQ-030 Reset mid-operation discards held items without counter increment.

Configuration
REQ-031 Macro PIPE_SKID_PERF_CNT_EN defined: stall_cnt and flush_cnt count per REQ-013/014, saturating at 2^CNT_W-1, never wrapping.
REQ-032 Macro undefined: ports stall_cnt and flush_cnt remain, tied to zero, no counter flops present; all other behaviour identical.

Verification
REQ-033 WIDTH=32, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 1,2,3, out_valid continuous.
REQ-034 out_ready=0, push 0xA,0xB -> after 2 cycles state SKID, in_ready=0, 0xC held off; raise out_ready -> 0xA,0xB,0xC in order, none lost.
REQ-035 State SKID, flush=1 with in_valid=1 in_data=0x55 -> next cycle out_valid=0, out_data=0, in_ready=1, 0x55 never appears; flush_cnt +1 (macro on).
REQ-036 State FULL holding 0x7, bubble=1 for 2 cycles, in_valid=1, out_ready=1 -> 0x7 consumed, in_ready=0 both cycles, out_valid=0 in second cycle, input accepted on bubble drop.
REQ-037 Macro on, CNT_W=2, out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; reset -> 0; macro off -> stall_cnt stays 0.
REQ-038 reset asserted in state SKID with flush=1 -> all outputs zero next cycle, flush_cnt unchanged at 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- single pipeline stage with a one-entry skid buffer.
//
// Keeps full throughput on a valid/ready handshake while in_ready is taken
// only from registered state and the bubble input. It never depends on
// out_ready. The main entry drives the outputs. The skid entry catches the
// one item that was accepted in the same cycle downstream stalled.
//
// Ports
//   clk        clock; all state updates on its rising edge
//   reset      synchronous, active-high; overrides every other input
//   in_valid   upstream presents in_data
//   in_ready   stage accepts in_data this cycle (!skid_v && !bubble)
//   in_data    upstream payload, WIDTH bits
//   out_valid  out_data valid to downstream
//   out_ready  downstream consumes this cycle
//   out_data   payload to downstream, zero when out_valid=0
//   flush      discard all held entries; overrides accept/consume/bubble
//   bubble     refuse upstream this cycle; downstream side unaffected
//   stall_cnt  saturating count of cycles with out_valid=1, out_ready=0
//   flush_cnt  saturating count of flush cycles that dropped a valid entry
//
// Build option
//   PIPE_SKID_PERF_CNT_EN  when defined, stall_cnt/flush_cnt count. When it
//                          is undefined, both ports are tied to zero and no
//                          counter flops are built.

module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // EMPTY: main_v=0; FULL: main_v=1, skid_v=0; SKID: both valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;
    logic [WIDTH-1:0] w_main_d_nxt;
    logic [WIDTH-1:0] w_skid_d_nxt;

    logic             w_main_v;
    logic             w_skid_v;
    logic             w_accept;
    logic             w_consume;

    assign w_main_v  = (r_state != ST_EMPTY);
    assign w_skid_v  = (r_state == ST_SKID);

    assign in_ready  = !w_skid_v && !bubble;
    assign out_valid = w_main_v;
    // main_d keeps its last value after a drain, so it is masked here.
    assign out_data  = w_main_v ? r_main_d : '0;

    assign w_accept  = in_valid && in_ready;
    assign w_consume = w_main_v && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_EMPTY;
            r_main_d <= '0;
            r_skid_d <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_main_d <= w_main_d_nxt;
            r_skid_d <= w_skid_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_main_d_nxt = r_main_d;
        w_skid_d_nxt = r_skid_d;

        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_main_d_nxt = '0;
            w_skid_d_nxt = '0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = ST_FULL;
                        w_main_d_nxt = in_data;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_consume) begin
                        w_main_d_nxt = in_data;
                    end else if (w_accept) begin
                        w_state_nxt  = ST_SKID;
                        w_skid_d_nxt = in_data;
                    end else if (w_consume) begin
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the consume path applies.
                    if (w_consume) begin
                        w_state_nxt  = ST_FULL;
                        w_main_d_nxt = r_skid_d;
                    end
                end
                default: begin
                    w_state_nxt  = ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;
    logic             w_flush_evt;

    assign w_stall_evt = w_main_v && !out_ready;
    // skid_v implies main_v, so main_v alone marks "at least one valid entry".
    assign w_flush_evt = flush && w_main_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg -- directed self-checking bench for pipe_skid_reg.
// Inputs change 1 time unit after a rising edge. Outputs are checked after
// that same settle delay, so they show the state from the edge just taken.

module tb_pipe_skid_reg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 2;

`ifdef PIPE_SKID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int unsigned n_assert;
    int unsigned n_fail;

    pipe_skid_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .bubble    (bubble),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf(input logic [31:0] v);
        return PERF ? v : 32'd0;
    endfunction

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;

        // Reset state
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_stall_cnt", {30'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {30'd0, flush_cnt}, 32'd0);
        bubble = 1'b1;
        #1;
        chk("rst_in_ready_bubble", {31'd0, in_ready}, 32'd0);
        bubble = 1'b0;
        #1;

        // Streaming: one item per cycle, one cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        chk("str_v1", {31'd0, out_valid}, 32'd1);
        chk("str_d1", out_data, 32'h11);
        in_data = 32'h22;
        step();
        chk("str_v2", {31'd0, out_valid}, 32'd1);
        chk("str_d2", out_data, 32'h22);
        chk("str_rdy2", {31'd0, in_ready}, 32'd1);
        in_data = 32'h33;
        step();
        chk("str_v3", {31'd0, out_valid}, 32'd1);
        chk("str_d3", out_data, 32'h33);
        in_valid = 1'b0;
        step();
        chk("str_drain_v", {31'd0, out_valid}, 32'd0);
        chk("str_drain_d", out_data, 32'd0);
        chk("str_stall_cnt", {30'd0, stall_cnt}, 32'd0);

        // Backpressure fills the skid entry, then drains in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk("bp_full_d", out_data, 32'hA);
        chk("bp_full_rdy", {31'd0, in_ready}, 32'd1);
        in_data = 32'hB;
        step();
        chk("bp_skid_d", out_data, 32'hA);
        chk("bp_skid_rdy", {31'd0, in_ready}, 32'd0);
        in_data = 32'hC;
        step();
        chk("bp_hold_d", out_data, 32'hA);
        chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_stall_cnt", {30'd0, stall_cnt}, perf(32'd2));
        out_ready = 1'b1;
        step();
        chk("bp_out_b", out_data, 32'hB);
        chk("bp_rdy_b", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_out_c", out_data, 32'hC);
        chk("bp_v_c", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp_empty_v", {31'd0, out_valid}, 32'd0);
        chk("bp_stall_hold", {30'd0, stall_cnt}, perf(32'd2));

        // Stall counter saturation at CNT_W=2, cleared by reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sat_rst", {30'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h7E;
        step();
        in_valid = 1'b0;
        chk("sat_c0", {30'd0, stall_cnt}, 32'd0);
        step();
        chk("sat_c1", {30'd0, stall_cnt}, perf(32'd1));
        step();
        chk("sat_c2", {30'd0, stall_cnt}, perf(32'd2));
        step();
        chk("sat_c3", {30'd0, stall_cnt}, perf(32'd3));
        step();
        chk("sat_c4", {30'd0, stall_cnt}, perf(32'd3));
        step();
        chk("sat_c5", {30'd0, stall_cnt}, perf(32'd3));
        chk("sat_held_d", out_data, 32'h7E);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sat_clear", {30'd0, stall_cnt}, 32'd0);
        chk("sat_clear_v", {31'd0, out_valid}, 32'd0);

        // Reset beats flush in SKID state; no flush counted
        in_valid = 1'b1;
        in_data  = 32'h3;
        step();
        in_data = 32'h4;
        step();
        chk("rf_skid_rdy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("rf_v", {31'd0, out_valid}, 32'd0);
        chk("rf_d", out_data, 32'd0);
        chk("rf_rdy", {31'd0, in_ready}, 32'd1);
        chk("rf_flush_cnt", {30'd0, flush_cnt}, 32'd0);
        chk("rf_stall_cnt", {30'd0, stall_cnt}, 32'd0);

        // Flush in SKID discards both entries and the offered item
        in_valid = 1'b1;
        in_data  = 32'h1;
        step();
        in_data = 32'h2;
        step();
        flush   = 1'b1;
        in_data = 32'h55;
        step();
        chk("fl_v", {31'd0, out_valid}, 32'd0);
        chk("fl_d", out_data, 32'd0);
        chk("fl_rdy", {31'd0, in_ready}, 32'd1);
        chk("fl_cnt", {30'd0, flush_cnt}, perf(32'd1));
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_no55_v", {31'd0, out_valid}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_empty_cnt", {30'd0, flush_cnt}, perf(32'd1));

        // Bubble: downstream drains, upstream held off until bubble drops
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h7;
        step();
        chk("bb_full_d", out_data, 32'h7);
        bubble  = 1'b1;
        in_data = 32'h8;
        #1;
        chk("bb_rdy0", {31'd0, in_ready}, 32'd0);
        step();
        chk("bb_v1", {31'd0, out_valid}, 32'd0);
        chk("bb_rdy1", {31'd0, in_ready}, 32'd0);
        step();
        chk("bb_v2", {31'd0, out_valid}, 32'd0);
        chk("bb_rdy2", {31'd0, in_ready}, 32'd0);
        bubble = 1'b0;
        #1;
        chk("bb_rdy_drop", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bb_acc_v", {31'd0, out_valid}, 32'd1);
        chk("bb_acc_d", out_data, 32'h8);
        step();
        chk("bb_end_v", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
